// File: rtl/cnn_accel_driver_pkg.sv
// rtl/cnn_accel_driver_pkg.sv - shared constants and FSM encoding for the CNN accelerator driver
//
// Purpose : default frame geometry, accelerator mode encoding, counter widths
//           and the driver state type.
// Ports   : none (package).

package cnn_accel_driver_pkg;

   localparam int   IMG_W           = 8;
   localparam int   KERNEL_TAPS     = 9;
   // 3 conv kernels plus 3 FC vectors, each 9 taps
   localparam int   W_BYTES_DEF     = 6 * KERNEL_TAPS;
   localparam int   D_BYTES_DEF     = IMG_W * IMG_W;
   localparam logic WEIGHT_MODE_DEF = 1'b1;
   localparam int   TIMEOUT_CYC_DEF = 256;

   localparam int   CNT_W           = 7;
   localparam int   WCNT_W          = 9;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD_W  = 3'd1,
      ST_FILL_D  = 3'd2,
      ST_BURST_D = 3'd3,
      ST_WAIT_R  = 3'd4,
      ST_HOLD_R  = 3'd5
   } drv_state_t;

endpackage

// File: rtl/cnn_img_buf.sv
// rtl/cnn_img_buf.sv - image byte buffer, one write port and one combinational read port
//
// Purpose : holds one full image so the data load can be replayed as a
//           gap-free burst.
// Ports   : clk            clock
//           wen/waddr/wdata write port
//           raddr -> rdata combinational read port

module cnn_img_buf
   import cnn_accel_driver_pkg::*;
#(
   parameter int DEPTH = D_BYTES_DEF,
   parameter int AW    = $clog2(DEPTH)
)(
   input  logic          clk,
   input  logic          wen,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   // No reset: contents are only read after a full fill of the current frame.
   always_ff @(posedge clk) begin
      if (wen) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/cnn_accel_driver.sv
// rtl/cnn_accel_driver.sv - host-side byte-load initiator for the CNN accelerator
//
// Purpose : accepts optional weights then one 8x8 image on a valid/ready byte
//           stream, forwards weights directly, buffers the image and replays it
//           as one gap-free ram_en burst, then waits for the result with a
//           timeout and returns it on a valid/ready result port.
// Ports   : clk, rst_n                  clock, async active-low reset
//           start, reload_weights       frame start pulse and weight reload request
//           s_valid, s_data, s_ready    upstream byte stream
//           acc_mode, acc_din, acc_ram_en  accelerator load port
//           acc_dout, acc_out_flag      accelerator result
//           m_valid, m_data, m_ready    result stream
//           busy, done, timeout_err     status

module cnn_accel_driver
   import cnn_accel_driver_pkg::*;
#(
   parameter int   W_BYTES     = W_BYTES_DEF,
   parameter int   D_BYTES     = D_BYTES_DEF,
   parameter logic WEIGHT_MODE = WEIGHT_MODE_DEF,
   parameter int   TIMEOUT_CYC = TIMEOUT_CYC_DEF
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       reload_weights,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   output logic       s_ready,
   output logic       acc_mode,
   output logic [7:0] acc_din,
   output logic       acc_ram_en,
   input  logic [7:0] acc_dout,
   input  logic       acc_out_flag,
   output logic       m_valid,
   output logic [7:0] m_data,
   input  logic       m_ready,
   output logic       busy,
   output logic       done,
   output logic       timeout_err
);

   localparam int                AW     = $clog2(D_BYTES);
   localparam logic [CNT_W-1:0]  W_LAST = CNT_W'(W_BYTES - 1);
   localparam logic [CNT_W-1:0]  D_LAST = CNT_W'(D_BYTES - 1);
   localparam logic [WCNT_W-1:0] T_LAST = WCNT_W'(TIMEOUT_CYC - 1);

   drv_state_t        state;
   logic [CNT_W-1:0]  cnt;
   logic [WCNT_W-1:0] wcnt;
   logic              weights_loaded;
   logic              s_fire;
   logic              buf_wen;
   logic [7:0]        buf_rdata;

   // s_ready and busy depend on state only, never on an input.
   assign s_ready = (state == ST_LOAD_W) || (state == ST_FILL_D);
   assign busy    = (state != ST_IDLE);
   assign s_fire  = s_valid & s_ready;
   assign buf_wen = s_fire & (state == ST_FILL_D);

   // The byte counter addresses the buffer for both the fill and the burst.
   cnn_img_buf #(
      .DEPTH (D_BYTES),
      .AW    (AW)
   ) u_img_buf (
      .clk   (clk),
      .wen   (buf_wen),
      .waddr (cnt[AW-1:0]),
      .wdata (s_data),
      .raddr (cnt[AW-1:0]),
      .rdata (buf_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         cnt            <= '0;
         wcnt           <= '0;
         weights_loaded <= 1'b0;
         acc_mode       <= ~WEIGHT_MODE;
         acc_din        <= 8'h00;
         acc_ram_en     <= 1'b0;
         m_valid        <= 1'b0;
         m_data         <= 8'h00;
         done           <= 1'b0;
         timeout_err    <= 1'b0;
      end else begin
         // acc_mode only shows WEIGHT_MODE on cycles that actually write a weight.
         acc_ram_en <= 1'b0;
         acc_mode   <= ~WEIGHT_MODE;
         done       <= 1'b0;

         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  timeout_err <= 1'b0;
                  cnt         <= '0;
                  state       <= (reload_weights || !weights_loaded) ? ST_LOAD_W : ST_FILL_D;
               end
            end

            ST_LOAD_W: begin
               if (s_fire) begin
                  acc_din    <= s_data;
                  acc_ram_en <= 1'b1;
                  acc_mode   <= WEIGHT_MODE;
                  if (cnt == W_LAST) begin
                     weights_loaded <= 1'b1;
                     cnt            <= '0;
                     state          <= ST_FILL_D;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end

            ST_FILL_D: begin
               if (s_fire) begin
                  if (cnt == D_LAST) begin
                     cnt   <= '0;
                     state <= ST_BURST_D;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end

            ST_BURST_D: begin
               // One buffer byte per cycle; ram_en appears one cycle after the read.
               acc_din    <= buf_rdata;
               acc_ram_en <= 1'b1;
               if (cnt == D_LAST) begin
                  cnt   <= '0;
                  wcnt  <= '0;
                  state <= ST_WAIT_R;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            ST_WAIT_R: begin
               // Flag is tested first so a flag on the timeout cycle still wins.
               if (acc_out_flag) begin
                  m_data  <= acc_dout;
                  m_valid <= 1'b1;
                  state   <= ST_HOLD_R;
               end else if (wcnt == T_LAST) begin
                  timeout_err <= 1'b1;
                  done        <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end

            ST_HOLD_R: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  done    <= 1'b1;
                  state   <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
